// File: rtl/ifid_skid_reg.sv
// -----------------------------------------------------------------------------
// ifid_skid_reg
//
// Elastic IF/ID pipeline register. Carries a fetched PC and instruction word
// from the fetch stage to the decode stage over a valid/ready handshake.
// A two-entry skid buffer (main + skid slot) sustains one entry per cycle
// while keeping in_ready_o a pure register output. A synchronous flush
// squashes everything held, and a saturating counter records how many valid
// entries were thrown away by flushes.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush_i      synchronous squash of all held entries (and same-cycle input)
//   in_valid_i   fetch stage presents an entry
//   in_ready_o   block can accept an entry (registered, = ~skid_v)
//   pc_addr_i    fetched PC
//   pc_instr_i   fetched instruction
//   out_valid_o  decode-side entry valid (= main_v)
//   out_ready_i  decode stage consumes the head entry
//   pc_addr_o    PC of the head entry (holds last loaded value when empty)
//   pc_instr_o   instruction of the head entry, NOP_INSTR when not valid
//   drop_cnt_o   saturating count of valid entries discarded by flush
// -----------------------------------------------------------------------------
module ifid_skid_reg #(
  parameter int unsigned              ADDR_W    = 32,
  parameter int unsigned              INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]       NOP_INSTR = '0,
  parameter int unsigned              CNT_W     = 8
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [ADDR_W-1:0]  pc_addr_i,
  input  logic [INSTR_W-1:0] pc_instr_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ADDR_W-1:0]  pc_addr_o,
  output logic [INSTR_W-1:0] pc_instr_o,
  output logic [CNT_W-1:0]   drop_cnt_o
);

  // Counter arithmetic is done two bits wider so a +3 never wraps before
  // the saturation compare.
  localparam int unsigned        SUM_W   = CNT_W + 2;
  localparam logic [SUM_W-1:0]   CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic               main_v;
  logic [ADDR_W-1:0]  main_addr;
  logic [INSTR_W-1:0] main_instr;

  logic               skid_v;
  logic [ADDR_W-1:0]  skid_addr;
  logic [INSTR_W-1:0] skid_instr;

  logic [CNT_W-1:0]   drop_cnt_q;

  // ---------------------------------------------------------------------------
  // Handshake events and slot control
  // ---------------------------------------------------------------------------
  logic in_fire;
  logic out_fire;
  logic main_free;   // main is empty or is being drained this cycle
  logic main_load;   // main captures a new entry this cycle
  logic main_from_skid;
  logic skid_load;   // skid captures the input this cycle

  assign in_fire  = in_valid_i & ~skid_v;
  assign out_fire = main_v & out_ready_i;

  assign main_free      = ~main_v | out_fire;
  assign main_from_skid = skid_v;
  // The skid entry is always older than the input, so it has priority for
  // main. While skid_v=1 the input is blocked, so the "skid just moved and
  // input arrives" case never occurs and the input only reaches skid when
  // main is held.
  assign main_load = ~flush_i & main_free & (skid_v | in_fire);
  assign skid_load = ~flush_i & in_fire & ~main_free;

  // ---------------------------------------------------------------------------
  // Valid flags
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush_i) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (main_free) begin
      main_v <= skid_v | in_fire;
      skid_v <= 1'b0;
    end else begin
      main_v <= 1'b1;
      skid_v <= skid_v | in_fire;
    end
  end

  // ---------------------------------------------------------------------------
  // Payload registers: loaded only on a move or an accept, otherwise they hold
  // (including after the slot empties), so pc_addr_o keeps its last value.
  // ---------------------------------------------------------------------------
  // NOTE: the payload registers are small flops, not a RAM, and downstream
  // observes pc_addr_o even when invalid, so they take the async reset too.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      main_addr  <= '0;
      main_instr <= '0;
    end else if (main_load) begin
      if (main_from_skid) begin
        main_addr  <= skid_addr;
        main_instr <= skid_instr;
      end else begin
        main_addr  <= pc_addr_i;
        main_instr <= pc_instr_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      skid_addr  <= '0;
      skid_instr <= '0;
    end else if (skid_load) begin
      skid_addr  <= pc_addr_i;
      skid_instr <= pc_instr_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Flush-drop counter
  // ---------------------------------------------------------------------------
  // Entries discarded by a flush: a held main entry not consumed this cycle,
  // a held skid entry, and an input accepted in the same cycle.
  logic [SUM_W-1:0] drop_inc;
  logic [SUM_W-1:0] cnt_sum;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    drop_inc = '0;
    if (flush_i) begin
      drop_inc = {{(SUM_W-1){1'b0}}, main_v & ~out_fire}
               + {{(SUM_W-1){1'b0}}, skid_v}
               + {{(SUM_W-1){1'b0}}, in_fire};
    end
  end

  assign cnt_sum = {2'b00, drop_cnt_q} + drop_inc;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (flush_i) begin
      drop_cnt_q <= (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready_o  = ~skid_v;
  assign out_valid_o = main_v;
  assign pc_addr_o   = main_addr;
  assign pc_instr_o  = main_v ? main_instr : NOP_INSTR;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_ifid_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_ifid_skid_reg
//
// Scoreboard bench for ifid_skid_reg. The stimulus task keeps a reference
// model of the block as an ordered queue of at most two held entries: accepted
// entries are pushed in order, the monitor pops the head whenever decode
// consumes it, and a flush empties the queue and adds the discarded count to a
// saturating drop counter. Directed sequences cover streaming, backpressure,
// both flush cases, counter saturation and asynchronous reset; a random phase
// exercises everything together.
// -----------------------------------------------------------------------------
module tb_ifid_skid_reg;

  localparam int unsigned        ADDR_W    = 32;
  localparam int unsigned        INSTR_W   = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned        CNT_W     = 2;
  localparam int                 CNT_MAX   = (1 << CNT_W) - 1;

  logic               clk_i = 1'b0;
  logic               rst_n;
  logic               flush_i;
  logic               in_valid_i;
  logic               in_ready_o;
  logic [ADDR_W-1:0]  pc_addr_i;
  logic [INSTR_W-1:0] pc_instr_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [ADDR_W-1:0]  pc_addr_o;
  logic [INSTR_W-1:0] pc_instr_o;
  logic [CNT_W-1:0]   drop_cnt_o;

  ifid_skid_reg #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .NOP_INSTR(NOP_INSTR),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .pc_addr_i  (pc_addr_i),
    .pc_instr_i (pc_instr_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .pc_addr_o  (pc_addr_o),
    .pc_instr_o (pc_instr_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t             exp_q[$];        // held entries, oldest first
  int                 exp_cnt;
  logic               exp_valid;
  logic               exp_ready;
  logic [ADDR_W-1:0]  exp_last_addr;   // payload of the last entry that was head
  logic               cur_flush;       // flush driven for the coming edge
  logic               cur_in_fire;     // input accepted at the coming edge
  logic               mon_en;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_cnt       = 0;
    exp_last_addr = '0;
    exp_valid     = 1'b0;
    exp_ready     = 1'b1;
    cur_flush     = 1'b0;
    cur_in_fire   = 1'b0;
  endtask

  // One clock cycle: account for the edge just taken, publish the expected
  // state, then drive the next inputs and predict whether they are accepted.
  task automatic cycle(input logic v, input logic [ADDR_W-1:0] a,
                       input logic [INSTR_W-1:0] ins, input logic ordy,
                       input logic fl);
    int d;
    @(posedge clk_i);
    #1;
    if (cur_flush) begin
      // Monitor already removed a consumed head; what remains was discarded,
      // plus the input accepted in the flush cycle.
      d = exp_q.size() + (cur_in_fire ? 1 : 0);
      exp_cnt = (exp_cnt + d > CNT_MAX) ? CNT_MAX : exp_cnt + d;
      exp_q.delete();
    end
    if (exp_q.size() > 0) exp_last_addr = exp_q[0].addr;
    exp_valid = (exp_q.size() > 0);
    exp_ready = (exp_q.size() < 2);

    in_valid_i  = v;
    pc_addr_i   = a;
    pc_instr_i  = ins;
    out_ready_i = ordy;
    flush_i     = fl;
    cur_in_fire = v && (exp_q.size() < 2);
    cur_flush   = fl;
    if (cur_in_fire && !fl) exp_q.push_back(entry_t'{a, ins});
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: mid-cycle sample of the DUT against the model
  // ---------------------------------------------------------------------------
  always @(negedge clk_i) begin
    if (mon_en) begin
      check("out_valid", out_valid_o, exp_valid);
      check("in_ready",  in_ready_o,  exp_ready);
      check("drop_cnt",  drop_cnt_o,  exp_cnt);
      if (!out_valid_o) begin
        check("nop_instr",  pc_instr_o, NOP_INSTR);
        check("stale_addr", pc_addr_o,  exp_last_addr);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL head: DUT presents addr 0x%0h but no entry expected at %0t", pc_addr_o, $time);
      end else begin
        check("head_addr",  pc_addr_o,  exp_q[0].addr);
        check("head_instr", pc_instr_o, exp_q[0].instr);
        if (out_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    mon_en      = 1'b0;
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    pc_addr_i   = '0;
    pc_instr_i  = '0;
    model_reset();

    repeat (3) @(posedge clk_i);
    #3;
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_in_ready",  in_ready_o,  1'b1);
    check("rst_pc_addr",   pc_addr_o,   '0);
    check("rst_pc_instr",  pc_instr_o,  NOP_INSTR);
    check("rst_drop_cnt",  drop_cnt_o,  '0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Idle, then streaming at full throughput.
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'(i * 4), $urandom, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Backpressure: fill main and skid, hold the third, then release.
    cycle(1'b1, 32'h100, 32'hA100, 1'b0, 1'b0);
    cycle(1'b1, 32'h104, 32'hA104, 1'b0, 1'b0);
    cycle(1'b1, 32'h108, 32'hA108, 1'b0, 1'b0);
    cycle(1'b1, 32'h108, 32'hA108, 1'b0, 1'b0);
    cycle(1'b1, 32'h108, 32'hA108, 1'b1, 1'b0);
    cycle(1'b1, 32'h108, 32'hA108, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush with both slots full and decode stalled: two entries dropped.
    cycle(1'b1, 32'h200, 32'hB200, 1'b0, 1'b0);
    cycle(1'b1, 32'h204, 32'hB204, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);

    // Flush while main is consumed and a new input fires: one entry dropped.
    cycle(1'b1, 32'h300, 32'hC300, 1'b1, 1'b0);
    cycle(1'b1, 32'h304, 32'hC304, 1'b1, 1'b1);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), $urandom, $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset in the middle of a cycle with entries held.
    cycle(1'b1, 32'h400, 32'hD400, 1'b0, 1'b0);
    cycle(1'b1, 32'h404, 32'hD404, 1'b0, 1'b0);
    @(posedge clk_i);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid_o, 1'b0);
    check("async_rst_in_ready",  in_ready_o,  1'b1);
    check("async_rst_pc_addr",   pc_addr_o,   '0);
    check("async_rst_pc_instr",  pc_instr_o,  NOP_INSTR);
    check("async_rst_drop_cnt",  drop_cnt_o,  '0);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    flush_i     = 1'b0;
    @(negedge clk_i);
    #1;
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;

    // Saturation from zero: 0 -> 2 -> 3 -> 3.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 32'(32'h500 + k * 8), $urandom, 1'b0, 1'b0);
      cycle(1'b1, 32'(32'h504 + k * 8), $urandom, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk_i);
    #1;
    check("drop_cnt_saturated", drop_cnt_o, CNT_MAX);

    // Short stream after reset to confirm normal operation resumes.
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'(32'h600 + i * 4), $urandom, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk_i);
    #1;
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
